// File: rtl/stu_upstream_arbiter_if.sv
// Bus bundle linking the PE array, the upstream arbiter and the stack upstream port.
// The master modport is the arbiter's view. The slave modport is the surrounding fabric's view.
interface stu_upstream_arbiter_if #(
  parameter int NUM_PE  = 64,
  parameter int PE_ID_W = 6,
  parameter int CNTL_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int DATA_W  = 64,
  parameter int OOB_W   = 32
);
  logic [NUM_PE-1:0]        pe__stu__valid;
  logic [NUM_PE*CNTL_W-1:0] pe__stu__cntl;
  logic [NUM_PE*TYPE_W-1:0] pe__stu__type;
  logic [NUM_PE*DATA_W-1:0] pe__stu__data;
  logic [NUM_PE*OOB_W-1:0]  pe__stu__oob_data;
  logic [NUM_PE-1:0]        stu__pe__ready;
  logic                     stu__sys__valid;
  logic [CNTL_W-1:0]        stu__sys__cntl;
  logic [TYPE_W-1:0]        stu__sys__type;
  logic [DATA_W-1:0]        stu__sys__data;
  logic [OOB_W-1:0]         stu__sys__oob_data;
  logic [PE_ID_W-1:0]       stu__sys__pe_id;
  logic                     sys__stu__ready;
  logic                     stu__sys__proto_err;

  modport master (
    input  pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data,
    input  sys__stu__ready,
    output stu__pe__ready,
    output stu__sys__valid, stu__sys__cntl, stu__sys__type, stu__sys__data,
    output stu__sys__oob_data, stu__sys__pe_id, stu__sys__proto_err
  );

  modport slave (
    output pe__stu__valid, pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data,
    output sys__stu__ready,
    input  stu__pe__ready,
    input  stu__sys__valid, stu__sys__cntl, stu__sys__type, stu__sys__data,
    input  stu__sys__oob_data, stu__sys__pe_id, stu__sys__proto_err
  );
endinterface

// File: rtl/stu_upstream_arbiter.sv
// Round-robin packet arbiter: locks onto one PE from SOM to EOM and forwards its words,
// tagged with the source PE id, through a 2-entry output FIFO.
module stu_upstream_arbiter #(
  parameter int NUM_PE  = 64,
  parameter int PE_ID_W = 6,
  parameter int CNTL_W  = 2,
  parameter int TYPE_W  = 2,
  parameter int DATA_W  = 64,
  parameter int OOB_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_poweron,
  stu_upstream_arbiter_if.master bus
);
  localparam int SOM_BIT = 0;
  localparam int EOM_BIT = 1;
  localparam int ENTRY_W = CNTL_W + TYPE_W + DATA_W + OOB_W + PE_ID_W;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [PE_ID_W-1:0]  r_grant;
  logic [PE_ID_W-1:0]  w_grant_next;
  logic [PE_ID_W-1:0]  r_rr_ptr;
  logic [PE_ID_W-1:0]  w_rr_next;
  logic                r_first;
  logic                w_first_next;
  logic                r_proto_err;
  logic                w_err_next;

  logic [ENTRY_W-1:0]  r_mem [2];
  logic                r_wr_ptr;
  logic                r_rd_ptr;
  logic [1:0]          r_count;

  logic [CNTL_W-1:0]   w_cntl [NUM_PE];
  logic [TYPE_W-1:0]   w_type [NUM_PE];
  logic [DATA_W-1:0]   w_data [NUM_PE];
  logic [OOB_W-1:0]    w_oob  [NUM_PE];
  logic [NUM_PE-1:0]   w_som_req;
  logic [PE_ID_W:0]    w_scan_sum [NUM_PE];
  logic [PE_ID_W-1:0]  w_scan_idx [NUM_PE];

  logic                w_hit;
  logic [PE_ID_W-1:0]  w_hit_idx;
  logic                w_fifo_space;
  logic                w_push;
  logic                w_pop;
  logic [NUM_PE-1:0]   w_ready;
  logic [ENTRY_W-1:0]  w_push_entry;

  // Per-PE field slices, plus the PE visited k steps after rr_ptr in the scan order.
  for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
    assign w_cntl[gi]     = bus.pe__stu__cntl[gi*CNTL_W +: CNTL_W];
    assign w_type[gi]     = bus.pe__stu__type[gi*TYPE_W +: TYPE_W];
    assign w_data[gi]     = bus.pe__stu__data[gi*DATA_W +: DATA_W];
    assign w_oob[gi]      = bus.pe__stu__oob_data[gi*OOB_W +: OOB_W];
    assign w_som_req[gi]  = bus.pe__stu__valid[gi] & w_cntl[gi][SOM_BIT];
    assign w_scan_sum[gi] = {1'b0, r_rr_ptr} + (PE_ID_W+1)'(gi);
    assign w_scan_idx[gi] = (w_scan_sum[gi] >= (PE_ID_W+1)'(NUM_PE))
                          ? PE_ID_W'(w_scan_sum[gi] - (PE_ID_W+1)'(NUM_PE))
                          : PE_ID_W'(w_scan_sum[gi]);
  end

  // The loop runs backwards, so the requester closest to rr_ptr is the last one written and wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int k = NUM_PE - 1; k >= 0; k--) begin
      if (w_som_req[w_scan_idx[k]]) begin
        w_hit     = 1'b1;
        w_hit_idx = w_scan_idx[k];
      end
    end
  end

  assign w_fifo_space = (r_count != 2'd2);
  assign w_pop        = (r_count != 2'd0) & bus.sys__stu__ready;
  assign w_push_entry = {w_cntl[r_grant], w_type[r_grant], w_data[r_grant], w_oob[r_grant], r_grant};

  always_comb begin
    w_state_next = r_state;
    w_grant_next = r_grant;
    w_rr_next    = r_rr_ptr;
    w_first_next = r_first;
    w_err_next   = r_proto_err;
    w_push       = 1'b0;
    w_ready      = '0;
    case (r_state)
      S_IDLE: begin
        if (w_hit) begin
          w_state_next = S_LOCKED;
          w_grant_next = w_hit_idx;
          w_first_next = 1'b1;
        end
      end
      S_LOCKED: begin
        w_ready[r_grant] = w_fifo_space;
        if (bus.pe__stu__valid[r_grant] && w_fifo_space) begin
          w_push       = 1'b1;
          w_first_next = 1'b0;
          // The first word must carry SOM, and no later word may carry it.
          if (r_first != w_cntl[r_grant][SOM_BIT]) begin
            w_err_next = 1'b1;
          end
          if (w_cntl[r_grant][EOM_BIT]) begin
            w_state_next = S_IDLE;
            w_rr_next    = (r_grant == PE_ID_W'(NUM_PE - 1)) ? '0 : r_grant + 1'b1;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_first     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_grant     <= w_grant_next;
      r_rr_ptr    <= w_rr_next;
      r_first     <= w_first_next;
      r_proto_err <= w_err_next;
    end
  end

  // Both entries are cleared on reset so that every output field reads zero afterwards.
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.stu__pe__ready      = w_ready;
  assign bus.stu__sys__valid     = (r_count != 2'd0);
  assign bus.stu__sys__proto_err = r_proto_err;
  assign {bus.stu__sys__cntl, bus.stu__sys__type, bus.stu__sys__data,
          bus.stu__sys__oob_data, bus.stu__sys__pe_id} = r_mem[r_rd_ptr];
endmodule
